// File: rtl/aoi_array_pipe.sv
`default_nettype none
// ============================================================================
// Module   : aoi_array_pipe
// Purpose  : Parametrised bank of CHANNELS and-or-invert gates, each the NOR of
//            TERMS maskable INPUTS-wide AND terms, behind a stallable valid
//            pipeline of PIPE registers. Optional per-channel output toggle
//            counters are enabled by defining AOI_TOGGLE_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module aoi_array_pipe #(
    parameter int CHANNELS = 2,
    parameter int TERMS    = 2,
    parameter int INPUTS   = 2,
    parameter int PIPE     = 2,
    parameter int CNT_W    = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [CHANNELS*TERMS*INPUTS-1:0]   in_data,
    input  logic [CHANNELS*TERMS-1:0]          term_en,
    input  logic                               stall,
    output logic                               out_valid,
    output logic [CHANNELS-1:0]                out_y,
    input  logic                               cnt_clr,
    output logic [CHANNELS*CNT_W-1:0]          toggle_cnt
);

    localparam int c_NTERM = CHANNELS * TERMS;

    logic [c_NTERM-1:0]  w_term;
    logic [CHANNELS-1:0] w_y;

    // Combinational AOI evaluation feeding the first pipeline register.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        for (genvar t = 0; t < TERMS; t++) begin : g_term
            assign w_term[c*TERMS+t] = term_en[c*TERMS+t]
                                     & (&in_data[((c*TERMS)+t)*INPUTS +: INPUTS]);
        end
        assign w_y[c] = ~|w_term[c*TERMS +: TERMS];
    end

    logic [PIPE-1:0]     r_vld;
    logic [CHANNELS-1:0] r_y   [PIPE];
    logic [PIPE-1:0]     w_vin;
    logic [CHANNELS-1:0] w_yin [PIPE];

    for (genvar s = 0; s < PIPE; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign w_vin[s] = in_valid;
            assign w_yin[s] = w_y;
        end else begin : g_body
            assign w_vin[s] = r_vld[s-1];
            assign w_yin[s] = r_y[s-1];
        end

        // y is loaded only with valid data, so a bubble leaves the previous
        // result in place and out_y naturally holds while out_valid is low.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld[s] <= 1'b0;
                r_y[s]   <= '1;
            end else if (!stall) begin
                r_vld[s] <= w_vin[s];
                if (w_vin[s]) begin
                    r_y[s] <= w_yin[s];
                end
            end
        end
    end

    assign out_valid = r_vld[PIPE-1];
    assign out_y     = r_y[PIPE-1];

`ifdef AOI_TOGGLE_CNT_EN
    logic                w_ld_last;
    logic [CNT_W-1:0]    r_cnt [CHANNELS];

    assign w_ld_last = !stall && w_vin[PIPE-1];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (reset || cnt_clr) begin
                r_cnt[c] <= '0;
            end else if (w_ld_last && (w_yin[PIPE-1][c] != r_y[PIPE-1][c])
                         && !(&r_cnt[c])) begin
                r_cnt[c] <= r_cnt[c] + CNT_W'(1);
            end
        end
        assign toggle_cnt[c*CNT_W +: CNT_W] = r_cnt[c];
    end
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign toggle_cnt       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aoi_array_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_aoi_array_pipe
// Purpose  : Scoreboard bench for aoi_array_pipe (default geometry).
// Revision : 1.0  initial release
// ============================================================================
module tb_aoi_array_pipe;

    localparam int CH = 2;
    localparam int TM = 2;
    localparam int IN = 2;
    localparam int PP = 2;
`ifdef AOI_TOGGLE_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic [CH*TM*IN-1:0]   in_data;
    logic [CH*TM-1:0]      term_en;
    logic                  stall;
    logic                  out_valid;
    logic [CH-1:0]         out_y;
    logic                  cnt_clr;
    logic [CH*CW-1:0]      toggle_cnt;

    aoi_array_pipe #(
        .CHANNELS (CH),
        .TERMS    (TM),
        .INPUTS   (IN),
        .PIPE     (PP),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .term_en    (term_en),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_y      (out_y),
        .cnt_clr    (cnt_clr),
        .toggle_cnt (toggle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CH-1:0] aoi_model(input logic [CH*TM*IN-1:0] d,
                                                input logic [CH*TM-1:0] e);
        logic [CH-1:0] y;
        logic          any;
        logic          p;
        for (int c = 0; c < CH; c++) begin
            any = 1'b0;
            for (int t = 0; t < TM; t++) begin
                p = e[c*TM+t];
                for (int i = 0; i < IN; i++) p = p & d[(c*TM+t)*IN+i];
                any = any | p;
            end
            y[c] = ~any;
        end
        return y;
    endfunction

    typedef struct {
        logic [CH-1:0] y;
        int            age;
    } ent_t;

    ent_t          sb[$];
    logic [CH-1:0] exp_hold;
    logic          exp_vld;
    logic [CW-1:0] exp_cnt [CH];
    bit            armed = 1'b0;
    bit            e_frz, e_clr, e_rst;

    // Reference model: bookkeeping at the rising edge, comparison at the falling edge.
    initial begin
        ent_t          ent;
        logic [CH*CW-1:0] cnt_vec;
        forever begin
            @(posedge clk);
            e_rst = reset;
            e_frz = stall;
            e_clr = cnt_clr;
            if (reset) begin
                armed    = 1'b1;
                sb.delete();
                exp_hold = '1;
                exp_vld  = 1'b0;
                for (int c = 0; c < CH; c++) exp_cnt[c] = '0;
            end else if (!stall) begin
                foreach (sb[i]) sb[i].age = sb[i].age + 1;
                if (in_valid) begin
                    ent.y   = aoi_model(in_data, term_en);
                    ent.age = 0;
                    sb.push_back(ent);
                end
                exp_vld = (sb.size() > 0) && (sb[0].age == PP - 1);
            end

            @(negedge clk);
            if (armed) begin
                chk("out_valid", out_valid, exp_vld);
                if (exp_vld && !e_frz && !e_rst) begin
                    ent = sb.pop_front();
                    chk("out_y", out_y, ent.y);
                    for (int c = 0; c < CH; c++) begin
                        if (ent.y[c] != exp_hold[c] && exp_cnt[c] != '1)
                            exp_cnt[c] = exp_cnt[c] + 1'b1;
                    end
                    exp_hold = ent.y;
                end else begin
                    chk("out_y_hold", out_y, exp_hold);
                end
                if (e_clr && !e_rst)
                    for (int c = 0; c < CH; c++) exp_cnt[c] = '0;
`ifdef AOI_TOGGLE_CNT_EN
                for (int c = 0; c < CH; c++) cnt_vec[c*CW +: CW] = exp_cnt[c];
`else
                cnt_vec = '0;
`endif
                chk("toggle_cnt", toggle_cnt, cnt_vec);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CH*TM*IN-1:0] d, input logic [CH*TM-1:0] e);
        in_valid = 1'b1;
        in_data  = d;
        term_en  = e;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        term_en  = '0;
        stall    = 1'b0;
        cnt_clr  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();

        // Single results, including masked terms
        send(8'h03, 4'hF);
        repeat (3) tick();
        send(8'h03, 4'hE);
        send(8'hC0, 4'hF);
        repeat (3) tick();

        // Back-to-back stream with a three-cycle stall on the third input
        in_valid = 1'b1;
        term_en  = 4'hF;
        in_data  = 8'h03;
        tick();
        in_data  = 8'h30;
        tick();
        in_data  = 8'h00;
        stall    = 1'b1;
        repeat (3) tick();
        stall    = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();

        // Reset with results in flight while stalled
        in_valid = 1'b1;
        in_data  = 8'h03;
        tick();
        in_data  = 8'h30;
        tick();
        in_valid = 1'b0;
        stall    = 1'b1;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        tick();
        stall    = 1'b0;
        repeat (3) tick();

        // Reset coinciding with a valid input: input must be dropped
        in_valid = 1'b1;
        in_data  = 8'h03;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();

        // Random traffic with stalls, bubbles and counter clears
        repeat (60) begin
            in_valid = 1'($urandom_range(1, 0));
            in_data  = 8'($urandom);
            term_en  = 4'($urandom);
            stall    = ($urandom_range(3, 0) == 0);
            cnt_clr  = ($urandom_range(15, 0) == 0);
            tick();
        end
        in_valid = 1'b0;
        stall    = 1'b0;
        cnt_clr  = 1'b0;
        repeat (4) tick();

        // Toggle counting: alternate channel 0 for five results
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send(8'h03, 4'hF);
        send(8'h00, 4'hF);
        send(8'h03, 4'hF);
        send(8'h00, 4'hF);
        send(8'h03, 4'hF);
        repeat (3) tick();
`ifdef AOI_TOGGLE_CNT_EN
        chk("toggle_sat_ch0", toggle_cnt[CW-1:0], 3);
        chk("toggle_ch1", toggle_cnt[2*CW-1:CW], 0);
`endif
        // Clear coinciding with a toggling result
        send(8'h00, 4'hF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr_y", out_y, 2'b11);
        chk("cnt_clr_cnt", toggle_cnt, 0);
        repeat (PP + 3) tick();

        chk("drain_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aoi_array_pipe.md
Name: aoi_array_pipe

Overview:
- Parametrised, pipelined and-or-invert bank for the TTL-equivalent logic library; next generation of the fixed dual 2-2 AOI part.
- Provides CHANNELS independent AOI outputs, each computed as NOT of the OR of TERMS product terms, with INPUTS inputs per term.
- Terms can be masked individually. The result passes through a stallable valid pipeline so it can sit on registered datapath boundaries.

Parameters:
- CHANNELS, 2, number of independent AOI outputs (1..16)
- TERMS, 2, product terms per channel (1..8)
- INPUTS, 2, inputs per product term (1..8)
- PIPE, 2, pipeline depth in clock cycles, input to out_y (1..4)
- CNT_W, 8, width of each per-channel toggle counter (optional feature only)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/term_en qualify this cycle
- in_data  input  CHANNELS*TERMS*INPUTS  gate inputs; bit index ((c*TERMS)+t)*INPUTS+i
- term_en  input  CHANNELS*TERMS  per-term enable; bit index c*TERMS+t; 0 forces term false
- stall  input  1  freeze entire pipeline
- out_valid  output  1  out_y carries a new result this cycle
- out_y  output  CHANNELS  registered AOI results, bit c = channel c
- cnt_clr  input  1  clear toggle counters (AOI_TOGGLE_CNT_EN only)
- toggle_cnt  output  CHANNELS*CNT_W  per-channel toggle counts, channel c at [c*CNT_W +: CNT_W] (AOI_TOGGLE_CNT_EN only)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Function: y[c] = ~| over t of ( term_en[c*TERMS+t] & (&in_data[term t inputs]) ).
- All TERMS masked gives y=1 for that channel.
- Computation happens in stage 1. Stages 2..PIPE are pure delay registers, each holding a {valid, y} pair.
- Latency: a result accepted at edge k (in_valid=1, stall=0) appears on out_y with out_valid=1 after edge k+PIPE-1, i.e. during cycle k+PIPE-1.
- Throughput: one result per cycle when stall=0.
- Stall:
  - stall=1 holds every stage register, out_valid and out_y unchanged.
  - in_valid is ignored and the input is not captured; upstream must hold data.
  - A stall lasting any number of cycles loses no result and duplicates none.
- Bubbles: in_valid=0 with stall=0 shifts a valid=0 slot in. The y value of a bubble stage is don't-care internally.
- out_y updates only when a valid result reaches the last stage. It holds its previous value while out_valid=0.
- Reset:
  - All stage valid bits clear; out_valid=0.
  - out_y = all ones, matching the AOI output with all inputs low.
  - Reset overrides stall.
  - Reset mid-stream discards all in-flight results. The first input after reset deasserts obeys normal latency.
- Simultaneous reset and in_valid: reset wins; input not captured.
- Structure:
  - Generic over parameters via generate loops; no per-width special cases.
  - PIPE=1 means the stage-1 register drives out_y directly.

Optional Feature:
- Macro: AOI_TOGGLE_CNT_EN
- Defined:
  - One CNT_W-bit counter per channel.
  - Increments when a valid result is loaded into out_y and that channel's bit differs from the previous out_y bit.
  - Saturates at all ones.
  - cnt_clr (synchronous) zeroes all counters and has priority over increment in the same cycle.
  - reset zeroes all counters.
  - Counters hold during stall.
- Undefined:
  - No counter logic.
  - toggle_cnt tied to 0 and cnt_clr ignored; ports retained so instantiations are unchanged.

Test Plan (defaults CHANNELS=2, TERMS=2, INPUTS=2, PIPE=2):
- Reset release -> out_valid=0 and out_y=2'b11 for the following cycles until the first valid input plus 1 cycle.
- in_data=8'h03, term_en=4'hF, in_valid=1 for one cycle -> exactly one cycle later out_valid=1, out_y=2'b10. Then out_valid=0 with out_y held at 2'b10.
- Same input with term_en=4'hE -> out_y=2'b11. Then in_data=8'hC0, term_en=4'hF -> out_y=2'b01.
- Back-to-back stream 8'h03, 8'h30, 8'h00 with stall=1 for 3 cycles after the second input -> outputs 2'b10, 2'b01, 2'b11, in order, none lost or repeated. out_valid/out_y frozen during the stall.
- reset asserted while 2 results are in flight, stall=1 -> next cycle out_valid=0, out_y=2'b11; no stale result ever emerges.
- With AOI_TOGGLE_CNT_EN, CNT_W=2:
  - Alternating inputs 8'h03 and 8'h00 for 5 results -> toggle_cnt channel 0 saturates at 3, channel 1 stays 0.
  - cnt_clr together with a toggling result -> counters read 0.
